// File: rtl/b11_scrambler_param.sv
// Parametrised b11-style input scrambler: captures a symbol, seeds from a wrapping
// counter, combines, reduces modulo MOD, biases, and emits the magnitude.
module b11_scrambler_param #(
  parameter int W     = 6,
  parameter int MOD   = 26,
  parameter int N_CYC = 25,
  parameter int BIAS0 = 21,
  parameter int BIAS1 = 42,
  parameter int BIAS2 = 7,
  parameter int BIAS3 = 28,
  parameter int REJ_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     x_in,
  input  logic             stbi,
  output logic [W-1:0]     x_out,
  output logic             out_valid,
  output logic             in_ready,
  output logic [REJ_W-1:0] rej_count
);

  localparam int CW = W + 3;

  localparam logic [W-1:0]         MOD_W  = W'(MOD);
  localparam logic [W-1:0]         NCYC_W = W'(N_CYC);
  localparam logic signed [CW-1:0] MOD_S  = CW'(MOD);
  localparam logic signed [CW-1:0] TOP_S  = CW'((1 << W) - 1);
  localparam logic signed [CW-1:0] B0_S   = CW'(BIAS0);
  localparam logic signed [CW-1:0] B1_S   = CW'(BIAS1);
  localparam logic signed [CW-1:0] B2_S   = CW'(BIAS2);
  localparam logic signed [CW-1:0] B3_S   = CW'(BIAS3);

  typedef enum logic [3:0] {
    S_INIT, S_WAIT, S_CLASS, S_SEED, S_COMB, S_REDN, S_REDP, S_BIAS, S_OUT
  } state_t;

  state_t                 state, state_nx;
  logic [W-1:0]           cont, cont_nx;
  logic [W-1:0]           r_in, r_in_nx;
  logic [W-1:0]           x_out_nx;
  logic                   valid_nx;
  logic [REJ_W-1:0]       rej_nx;
  logic signed [CW-1:0]   cont1, cont1_nx;
  logic signed [CW-1:0]   r_ext, c_ext, cont1_neg;

  assign r_ext     = $signed({3'b000, r_in});
  assign c_ext     = $signed({3'b000, cont});
  assign cont1_neg = -cont1;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    cont_nx   = cont;
    r_in_nx   = r_in;
    cont1_nx  = cont1;
    x_out_nx  = x_out;
    valid_nx  = 1'b0;
    rej_nx    = rej_count;
    in_ready  = 1'b0;

    unique case (state)
      S_INIT: begin
        cont_nx  = '0;
        r_in_nx  = x_in;
        x_out_nx = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        r_in_nx  = x_in;
        if (!stbi) state_nx = S_CLASS;
      end
      S_CLASS: begin
        if (r_in == '0 || r_in == '1) begin
          cont_nx  = (cont < NCYC_W) ? cont + 1'b1 : '0;
          cont1_nx = r_ext;
          state_nx = S_OUT;
        end else if (r_in <= MOD_W) begin
          state_nx = S_SEED;
        end else begin
          if (rej_count != '1) rej_nx = rej_count + 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_SEED: begin
        cont1_nx = r_in[0] ? (c_ext <<< 1) : c_ext;
        state_nx = S_COMB;
      end
      // The reduction loop tests the value being written, so a loop state is
      // only entered when a subtraction/addition is really due: k iterations cost k cycles.
      S_COMB: begin
        if (r_in[1]) begin
          cont1_nx = r_ext + cont1;
          state_nx = (cont1_nx > MOD_S) ? S_REDN : S_BIAS;
        end else begin
          cont1_nx = r_ext - cont1;
          state_nx = (cont1_nx > TOP_S) ? S_REDP : S_BIAS;
        end
      end
      S_REDN: begin
        cont1_nx = cont1 - MOD_S;
        state_nx = (cont1_nx > MOD_S) ? S_REDN : S_BIAS;
      end
      S_REDP: begin
        cont1_nx = cont1 + MOD_S;
        state_nx = (cont1_nx > TOP_S) ? S_REDP : S_BIAS;
      end
      S_BIAS: begin
        case (r_in[3:2])
          2'b00:   cont1_nx = cont1 - B0_S;
          2'b01:   cont1_nx = cont1 - B1_S;
          2'b10:   cont1_nx = cont1 + B2_S;
          default: cont1_nx = cont1 + B3_S;
        endcase
        state_nx = S_OUT;
      end
      S_OUT: begin
        x_out_nx = cont1[CW-1] ? cont1_neg[W-1:0] : cont1[W-1:0];
        valid_nx = 1'b1;
        state_nx = S_WAIT;
      end
      default: state_nx = S_INIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      cont      <= '0;
      cont1     <= '0;
      r_in      <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
      rej_count <= '0;
    end else begin
      state     <= state_nx;
      cont      <= cont_nx;
      cont1     <= cont1_nx;
      r_in      <= r_in_nx;
      x_out     <= x_out_nx;
      out_valid <= valid_nx;
      rej_count <= rej_nx;
    end
  end

endmodule

// File: tb/tb_b11_scrambler_param.sv
// Directed, table-driven bench for b11_scrambler_param with hand-computed results;
// a second instance with a 2-bit reject counter covers saturation.
module tb_b11_scrambler_param;

  localparam int W = 6;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] x_in  = '0;
  logic         stbi  = 1'b1;

  logic [W-1:0] x_out, x_out_s;
  logic         out_valid, out_valid_s;
  logic         in_ready, in_ready_s;
  logic [7:0]   rej_count;
  logic [1:0]   rej_count_s;

  int checks = 0;
  int errors = 0;

  b11_scrambler_param dut (
    .clock(clock), .reset(reset), .x_in(x_in), .stbi(stbi),
    .x_out(x_out), .out_valid(out_valid), .in_ready(in_ready), .rej_count(rej_count)
  );

  b11_scrambler_param #(.REJ_W(2)) dut_s (
    .clock(clock), .reset(reset), .x_in(x_in), .stbi(stbi),
    .x_out(x_out_s), .out_valid(out_valid_s), .in_ready(in_ready_s), .rej_count(rej_count_s)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    bit           accept;
    int           exp_x;
    int           exp_lat;
    int           exp_rej;
  } vec_t;

  vec_t vecs[10];

  // Capture one symbol from WAIT and measure edges from the capturing edge to out_valid.
  task automatic send(input logic [W-1:0] x, input bit accept, input int exp_x,
                      input int exp_lat, input string tag);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    x_in = x;
    stbi = 1'b0;
    @(posedge clock);
    @(negedge clock);
    stbi = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (accept) begin
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " x_out"}, x_out, exp_x);
      @(negedge clock);
      check({tag, " pulse"}, out_valid, 0);
    end else begin
      check({tag, " no out_valid"}, lat, 0);
    end
  endtask

  // Release reset with stbi high for the INIT edge, then capture x_in=0.
  task automatic startup(input string tag);
    x_in  = '0;
    stbi  = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    stbi = 1'b0;
    @(negedge clock);
    stbi = 1'b1;
    check({tag, " busy"}, in_ready, 0);
    @(negedge clock);
    check({tag, " edge3 valid"}, out_valid, 0);
    @(negedge clock);
    check({tag, " edge4 valid"}, out_valid, 1);
    check({tag, " edge4 x_out"}, x_out, 0);
    @(negedge clock);
    check({tag, " edge5 valid"}, out_valid, 0);
    check({tag, " edge5 ready"}, in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{x: 6'd5,  accept: 1'b1, exp_x: 37, exp_lat: 5, exp_rej: 0};
    vecs[1] = '{x: 6'd63, accept: 1'b1, exp_x: 63, exp_lat: 2, exp_rej: 0};
    vecs[2] = '{x: 6'd63, accept: 1'b1, exp_x: 63, exp_lat: 2, exp_rej: 0};
    vecs[3] = '{x: 6'd63, accept: 1'b1, exp_x: 63, exp_lat: 2, exp_rej: 0};
    vecs[4] = '{x: 6'd26, accept: 1'b1, exp_x: 10, exp_lat: 6, exp_rej: 0};
    vecs[5] = '{x: 6'd30, accept: 1'b0, exp_x: 0,  exp_lat: 0, exp_rej: 1};
    vecs[6] = '{x: 6'd0,  accept: 1'b1, exp_x: 0,  exp_lat: 2, exp_rej: 1};
    vecs[7] = '{x: 6'd7,  accept: 1'b1, exp_x: 27, exp_lat: 5, exp_rej: 1};
    vecs[8] = '{x: 6'd12, accept: 1'b1, exp_x: 36, exp_lat: 5, exp_rej: 1};
    vecs[9] = '{x: 6'd40, accept: 1'b0, exp_x: 0,  exp_lat: 0, exp_rej: 2};

    repeat (2) @(negedge clock);
    check("reset x_out", x_out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset rej_count", rej_count, 0);

    startup("start");

    do_reset();
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].x, vecs[v].accept, vecs[v].exp_x, vecs[v].exp_lat, $sformatf("vec%0d", v));
      check($sformatf("vec%0d rej", v), rej_count, vecs[v].exp_rej);
      check($sformatf("vec%0d rej_s", v), rej_count_s,
            (vecs[v].exp_rej > 3) ? 3 : vecs[v].exp_rej);
    end

    send(6'd27, 1'b0, 0, 0, "rej27");
    send(6'd50, 1'b0, 0, 0, "rej50");
    send(6'd62, 1'b0, 0, 0, "rej62");
    check("rej total", rej_count, 5);
    check("rej saturated", rej_count_s, 3);

    // cont=4, x=26: cont1=30, one REDN pass pending; reset lands inside it.
    @(negedge clock);
    x_in = 6'd26;
    stbi = 1'b0;
    @(posedge clock);
    @(negedge clock);
    stbi = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset x_out", x_out, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset rej_count", rej_count, 0);
    check("midreset rej_count_s", rej_count_s, 0);
    check("midreset in_ready", in_ready, 0);
    @(negedge clock);
    @(negedge clock);
    startup("restart");

    do_reset();
    for (int n = 0; n < 25; n++) begin
      send(6'd0, 1'b1, 0, 2, $sformatf("zero%0d", n));
    end
    send(6'd1, 1'b1, 6,  5, "wrap_top");
    send(6'd0, 1'b1, 0,  2, "wrap_zero");
    send(6'd1, 1'b1, 20, 5, "wrap_base");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
